filter_out_sink: RTL
====================

# filter_out_sink

Output-side receiver for the FM-radio filter blocks (FIR/IIR). It drives the filter's `rd_en` backpressure input and captures each result word presented with the filter's one-cycle `done` pulse. It buffers results in a first-word-fall-through FIFO for the next pipeline stage, and reports fill level, a sticky overflow flag and a running sample count.

## Interface
Parameters:
- `DATA_WIDTH`, 32: sample width; matches the filter's `filteredData`.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `LW`, `$clog2(DEPTH)+1`: width of `level`; derived localparam.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `filt_data`  in  DATA_WIDTH  filter result; connects to `filteredData`.
- `filt_done`  in  1  one-cycle result strobe; connects to `done`.
- `filt_rd_en`  out  1  space-available to the filter; connects to the filter's `rd_en`.
- `out_dout`  out  DATA_WIDTH  FIFO head word, valid while `out_empty`=0.
- `out_empty`  out  1  FIFO empty.
- `out_rd_en`  in  1  downstream pop request.
- `level`  out  LW  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky; a result was dropped.
- `sample_count`  out  32  accepted results since reset; wraps modulo 2^32.

## Operation
- Storage is a register array `mem[DEPTH]` with a write pointer `wp` and a read pointer `rp`, each log2(DEPTH) bits wide, plus a registered `level`.
- Both pointers wrap from DEPTH-1 to 0.
- `filt_rd_en = (level < DEPTH)`. It is decoded combinationally from registered state only, with no path from `filt_done` or `out_rd_en`.
  - The filter commits to a computation only while `rd_en`=1 and has at most one result in flight.
  - With `level < DEPTH` at commit time, a slot is guaranteed when `done` arrives.
- Write: `wr = filt_done && (level < DEPTH || rd)`.
  - On `wr`: store `mem[wp] <= filt_data`, advance `wp`, increment `sample_count`.
- Read: `rd = out_rd_en && level != 0`.
  - On `rd`: advance `rp`.
  - `out_rd_en` while empty is ignored; no state changes.
- Level update: `level` += `wr` − `rd`. A simultaneous write and read leaves `level` unchanged.
- Full with read: `filt_done` while `level==DEPTH` and `rd`=1 is accepted, with no overflow.
- Full without read: `filt_done` while `level==DEPTH` and `rd`=0 drops the word. This sets `overflow`=1, leaves `sample_count` unchanged, and leaves pointers unchanged. `overflow` clears only on reset.
- Output: `out_dout = mem[rp]`, read combinationally (first-word-fall-through). `out_empty = (level==0)`.
- `filt_data` is sampled only on `filt_done` cycles; its value is ignored at all other times.
- Arithmetic: none on data; words are stored bit-exact, with no sign handling or saturation.

## Timing
- Reset values: `level`=0, `wp`=`rp`=0, `overflow`=0, `sample_count`=0, `out_empty`=1, `filt_rd_en`=1. `out_dout` is don't-care while empty; the array is not cleared.
- Reset mid-operation: all buffered words are discarded. A `filt_done` in the reset cycle is ignored.
- Write latency: `filt_done` at edge k makes the word visible on `out_dout`, with `out_empty`=0, in the cycle after edge k.
- Pop latency: `out_rd_en` at edge k shows the next word, or `out_empty`=1, after edge k.
- Backpressure: `filt_rd_en` falls in the cycle after the write that makes `level`=DEPTH. It rises in the cycle after the first pop from full.
- Throughput: one write and one read per cycle sustained.

## Test plan
1. Reset then idle, DEPTH=4: `out_empty`=1, `filt_rd_en`=1, `level`=0, `overflow`=0, `sample_count`=0.
2. Writes with no reads, DEPTH=4: pulse `filt_done` with 0x000000B2, 0xFFFFFD66, 0x1, 0x2.
   - Required: `level` steps 1..4 and `filt_rd_en`=0 after the 4th write.
   - Then pop 4 times: `out_dout` reads 0xB2, 0xFFFFFD66, 0x1, 0x2 in order, then `out_empty`=1, and `filt_rd_en`=1 after the first pop.
3. Full, then `filt_done` with 0x5 and no read: word dropped, `overflow`=1, `level`=4, `sample_count`=4.
   - Pop all: 0x5 never appears. `overflow` stays 1 until reset.
4. Full, then `filt_done` with 0x7 together with `out_rd_en`: `level` stays 4, `overflow`=0.
   - Contents afterwards: oldest word removed, 0x7 at the tail, `sample_count` increments.
5. Pointer wrap, DEPTH=4: 10 interleaved write/pop pairs with data 0..9.
   - Required: `out_dout` returns 0..9 in order, `level` never exceeds 1, and `out_rd_en` on empty is ignored.
6. Integration with IIR (TAP_COUNT=2, MULT_PER_CYCLE=1), `out_rd_en` held 0, DEPTH=4, continuous input.
   - Required: exactly 4 results captured, then the IIR stalls in its shift state; `overflow`=0.
   - Releasing `out_rd_en` resumes output with no lost samples.

Source files
------------

// File: rtl/filter_out_sink.sv
// Output-side receiver for the FIR/IIR filters: FWFT result FIFO with backpressure,
// fill level, sticky overflow and a running accepted-sample count.
module filter_out_sink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] filt_data,
  input  logic                  filt_done,
  output logic                  filt_rd_en,
  output logic [DATA_WIDTH-1:0] out_dout,
  output logic                  out_empty,
  input  logic                  out_rd_en,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [31:0]           sample_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wp;
  logic [AW-1:0]         r_rp;
  logic [LW-1:0]         r_level;
  logic                  r_overflow;
  logic [31:0]           r_sample_count;

  logic w_wr;
  logic w_rd;
  logic w_drop;

  always_comb begin
    w_rd   = out_rd_en && (r_level != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    w_wr   = filt_done && ((r_level < FullLevel) || w_rd);
    w_drop = filt_done && !w_wr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp           <= '0;
      r_rp           <= '0;
      r_level        <= '0;
      r_overflow     <= 1'b0;
      r_sample_count <= '0;
    end else begin
      if (w_wr) begin
        r_wp           <= r_wp + AW'(1);
        r_sample_count <= r_sample_count + 32'd1;
      end
      if (w_rd) begin
        r_rp <= r_rp + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage is never cleared; contents are meaningless while empty.
  always_ff @(posedge clock) begin
    if (!reset && w_wr) begin
      r_mem[r_wp] <= filt_data;
    end
  end

  always_comb begin
    filt_rd_en   = (r_level < FullLevel);
    out_dout     = r_mem[r_rp];
    out_empty    = (r_level == '0);
    level        = r_level;
    overflow     = r_overflow;
    sample_count = r_sample_count;
  end

endmodule
